// File: rtl/fetch_pc_if.sv
// Fetch-PC bus: the pipeline inputs that steer the fetch PC and the outputs that
// the fetch PC unit returns to imem, IF/ID and the branch predictor.
interface fetch_pc_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             stall;
  logic [PC_W-1:0]  pre_pc;
  logic             ex_valid;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_taken;
  logic [PC_W-1:0]  ex_target;
  logic [PC_W-1:0]  ex_pred_pc;

  logic [PC_W-1:0]  pc;
  logic             fetch_valid;
  logic             flush;
  logic             risk_Ctrl_delay;
  logic [PC_W-1:0]  branch_pc;
  logic [PC_W-1:0]  branch_target;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    input  stall, pre_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_pc,
    output pc, fetch_valid, flush, risk_Ctrl_delay, branch_pc, branch_target,
           br_count, mp_count
  );

  modport slave (
    output stall, pre_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_pc,
    input  pc, fetch_valid, flush, risk_Ctrl_delay, branch_pc, branch_target,
           br_count, mp_count
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC stage: selects next PC (redirect / hold / predicted), raises flush on a
// mispredict, reports the corrected branch to the BHT one cycle later, counts branches.
module fetch_pc_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter int              CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  fetch_pc_if.master bus
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             risk_q, risk_d;
  logic [PC_W-1:0]  branch_pc_q, branch_pc_d;
  logic [PC_W-1:0]  branch_target_q, branch_target_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mp_count_q, mp_count_d;

  logic [PC_W-1:0]  actual_pc_s;
  logic             mispredict_s;
  logic             fetch_valid_s;

  // Resolve the real next PC of the executing branch; BOOT cannot see a legal ex_valid.
  always_comb begin
    actual_pc_s  = bus.ex_pc + PC_W'(4);
    mispredict_s = 1'b0;
    if (bus.ex_taken) begin
      actual_pc_s = bus.ex_target;
    end else begin
      actual_pc_s = bus.ex_pc + PC_W'(4);
    end
    if (bus.ex_valid && (state_q != ST_BOOT)) begin
      mispredict_s = (actual_pc_s != bus.ex_pred_pc);
    end else begin
      mispredict_s = 1'b0;
    end
  end

  // Fetch state sequencing and the fetch_valid qualifier.
  always_comb begin
    state_d       = state_q;
    fetch_valid_s = 1'b0;
    case (state_q)
      ST_BOOT: begin
        fetch_valid_s = 1'b0;
        state_d       = ST_RUN;
      end
      ST_RUN, ST_REDIR: begin
        if (state_q == ST_RUN) begin
          fetch_valid_s = ~bus.stall & ~mispredict_s;
        end else begin
          fetch_valid_s = ~bus.stall;
        end
        if (mispredict_s) begin
          state_d = ST_REDIR;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        fetch_valid_s = 1'b0;
        state_d       = ST_BOOT;
      end
    endcase
  end

  // Next PC, delayed BHT update and saturating counters.
  always_comb begin
    pc_d            = pc_q;
    risk_d          = mispredict_s;
    branch_pc_d     = branch_pc_q;
    branch_target_d = branch_target_q;
    br_count_d      = br_count_q;
    mp_count_d      = mp_count_q;

    if (mispredict_s) begin
      pc_d            = actual_pc_s;
      branch_pc_d     = bus.ex_pc;
      branch_target_d = actual_pc_s;
    end else if (bus.stall || (state_q == ST_BOOT)) begin
      pc_d = pc_q;
    end else begin
      pc_d = bus.pre_pc;
    end

    if (bus.ex_valid && (br_count_q != {CNT_W{1'b1}})) begin
      br_count_d = br_count_q + CNT_W'(1);
    end else begin
      br_count_d = br_count_q;
    end
    if (mispredict_s && (mp_count_q != {CNT_W{1'b1}})) begin
      mp_count_d = mp_count_q + CNT_W'(1);
    end else begin
      mp_count_d = mp_count_q;
    end
  end

  // State registers; reset discards any pending redirect report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_PC;
      risk_q          <= 1'b0;
      branch_pc_q     <= {PC_W{1'b0}};
      branch_target_q <= {PC_W{1'b0}};
      br_count_q      <= {CNT_W{1'b0}};
      mp_count_q      <= {CNT_W{1'b0}};
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      risk_q          <= risk_d;
      branch_pc_q     <= branch_pc_d;
      branch_target_q <= branch_target_d;
      br_count_q      <= br_count_d;
      mp_count_q      <= mp_count_d;
    end
  end

  assign bus.pc              = pc_q;
  assign bus.fetch_valid     = fetch_valid_s;
  assign bus.flush           = mispredict_s;
  assign bus.risk_Ctrl_delay = risk_q;
  assign bus.branch_pc       = branch_pc_q;
  assign bus.branch_target   = branch_target_q;
  assign bus.br_count        = br_count_q;
  assign bus.mp_count        = mp_count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, randomized run against a
// behavioural model, and saturation / mid-redirect reset sequences.
module tb_fetch_pc_unit;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  fetch_pc_if #(.PC_W(32), .CNT_W(32)) bus ();
  fetch_pc_if #(.PC_W(32), .CNT_W(3))  sbus ();

  assign sbus.stall      = bus.stall;
  assign sbus.pre_pc     = bus.pre_pc;
  assign sbus.ex_valid   = bus.ex_valid;
  assign sbus.ex_pc      = bus.ex_pc;
  assign sbus.ex_taken   = bus.ex_taken;
  assign sbus.ex_target  = bus.ex_target;
  assign sbus.ex_pred_pc = bus.ex_pred_pc;

  fetch_pc_unit #(.PC_W(32), .RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fetch_pc_unit #(.PC_W(32), .RESET_PC(32'h0000_0000), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [31:0] pre_pc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_pc;
    logic [31:0] e_pc;
    logic        e_fv;
    logic        e_flush;
    logic        e_risk;
    logic [31:0] e_bpc;
    logic [31:0] e_btgt;
    logic [31:0] e_br;
    logic [31:0] e_mp;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic st, logic [31:0] pre, logic ev, logic [31:0] epc,
                              logic tk, logic [31:0] tgt, logic [31:0] pred,
                              logic [31:0] xpc, logic fv, logic fl, logic rk,
                              logic [31:0] bpc, logic [31:0] btgt,
                              logic [31:0] br, logic [31:0] mp);
    vec_t v;
    v.stall = st; v.pre_pc = pre; v.ex_valid = ev; v.ex_pc = epc;
    v.ex_taken = tk; v.ex_target = tgt; v.ex_pred_pc = pred;
    v.e_pc = xpc; v.e_fv = fv; v.e_flush = fl; v.e_risk = rk;
    v.e_bpc = bpc; v.e_btgt = btgt; v.e_br = br; v.e_mp = mp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic [31:0] pre, input logic ev,
                       input logic [31:0] epc, input logic tk,
                       input logic [31:0] tgt, input logic [31:0] pred);
    bus.stall = st; bus.pre_pc = pre; bus.ex_valid = ev; bus.ex_pc = epc;
    bus.ex_taken = tk; bus.ex_target = tgt; bus.ex_pred_pc = pred;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".pc"},     64'(bus.pc), 64'h0);
    chk({tag, ".fv"},     64'(bus.fetch_valid), 64'h0);
    chk({tag, ".flush"},  64'(bus.flush), 64'h0);
    chk({tag, ".risk"},   64'(bus.risk_Ctrl_delay), 64'h0);
    chk({tag, ".bpc"},    64'(bus.branch_pc), 64'h0);
    chk({tag, ".btgt"},   64'(bus.branch_target), 64'h0);
    chk({tag, ".br"},     64'(bus.br_count), 64'h0);
    chk({tag, ".mp"},     64'(bus.mp_count), 64'h0);
    chk({tag, ".sat_mp"}, 64'(sbus.mp_count), 64'h0);
  endtask

  // Leaves the bench at posedge+1 of the BOOT cycle.
  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Behavioural model state
  logic [31:0] m_pc, m_bpc, m_btgt;
  logic        m_first, m_prev_mp, m_risk;
  longint      m_br, m_mp, m_sbr, m_smp;

  initial begin
    logic [31:0] act, pre, epc, tgt, pred;
    logic        st, ev, tk, mp, fv;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;

    //         st pre     ev epc      tk tgt       pred    | pc      fv fl rk bpc    btgt   br mp
    tbl[0]  = mk(0, 32'h04, 0, 32'h0,   0, 32'h0,   32'h0,   32'h00,  0, 0, 0, 32'h0,   32'h0,   0, 0);
    tbl[1]  = mk(0, 32'h04, 0, 32'h0,   0, 32'h0,   32'h0,   32'h00,  1, 0, 0, 32'h0,   32'h0,   0, 0);
    tbl[2]  = mk(0, 32'h08, 0, 32'h0,   0, 32'h0,   32'h0,   32'h04,  1, 0, 0, 32'h0,   32'h0,   0, 0);
    tbl[3]  = mk(0, 32'h10, 0, 32'h0,   0, 32'h0,   32'h0,   32'h08,  1, 0, 0, 32'h0,   32'h0,   0, 0);
    tbl[4]  = mk(1, 32'h14, 0, 32'h0,   0, 32'h0,   32'h0,   32'h10,  0, 0, 0, 32'h0,   32'h0,   0, 0);
    tbl[5]  = mk(1, 32'h14, 0, 32'h0,   0, 32'h0,   32'h0,   32'h10,  0, 0, 0, 32'h0,   32'h0,   0, 0);
    tbl[6]  = mk(1, 32'h14, 0, 32'h0,   0, 32'h0,   32'h0,   32'h10,  0, 0, 0, 32'h0,   32'h0,   0, 0);
    tbl[7]  = mk(0, 32'h20, 0, 32'h0,   0, 32'h0,   32'h0,   32'h10,  1, 0, 0, 32'h0,   32'h0,   0, 0);
    tbl[8]  = mk(0, 32'h24, 1, 32'h20,  1, 32'h80,  32'h24,  32'h20,  0, 1, 0, 32'h0,   32'h0,   0, 0);
    tbl[9]  = mk(0, 32'h84, 0, 32'h0,   0, 32'h0,   32'h0,   32'h80,  1, 0, 1, 32'h20,  32'h80,  1, 1);
    tbl[10] = mk(0, 32'h88, 1, 32'h40,  0, 32'h999, 32'h44,  32'h84,  1, 0, 0, 32'h20,  32'h80,  1, 1);
    tbl[11] = mk(0, 32'h8c, 0, 32'h0,   0, 32'h0,   32'h0,   32'h88,  1, 0, 0, 32'h20,  32'h80,  2, 1);
    tbl[12] = mk(1, 32'h90, 1, 32'h100, 0, 32'h300, 32'h200, 32'h8c,  0, 1, 0, 32'h20,  32'h80,  2, 1);
    tbl[13] = mk(1, 32'h108,0, 32'h0,   0, 32'h0,   32'h0,   32'h104, 0, 0, 1, 32'h100, 32'h104, 3, 2);
    tbl[14] = mk(0, 32'h108,0, 32'h0,   0, 32'h0,   32'h0,   32'h104, 1, 0, 0, 32'h100, 32'h104, 3, 2);
    tbl[15] = mk(0, 32'h10c,0, 32'h0,   0, 32'h0,   32'h0,   32'h108, 1, 0, 0, 32'h100, 32'h104, 3, 2);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].stall, tbl[i].pre_pc, tbl[i].ex_valid, tbl[i].ex_pc,
            tbl[i].ex_taken, tbl[i].ex_target, tbl[i].ex_pred_pc);
      @(negedge clk);
      chk($sformatf("t%0d.pc", i),    64'(bus.pc),              64'(tbl[i].e_pc));
      chk($sformatf("t%0d.fv", i),    64'(bus.fetch_valid),     64'(tbl[i].e_fv));
      chk($sformatf("t%0d.flush", i), 64'(bus.flush),           64'(tbl[i].e_flush));
      chk($sformatf("t%0d.risk", i),  64'(bus.risk_Ctrl_delay), 64'(tbl[i].e_risk));
      chk($sformatf("t%0d.bpc", i),   64'(bus.branch_pc),       64'(tbl[i].e_bpc));
      chk($sformatf("t%0d.btgt", i),  64'(bus.branch_target),   64'(tbl[i].e_btgt));
      chk($sformatf("t%0d.br", i),    64'(bus.br_count),        64'(tbl[i].e_br));
      chk($sformatf("t%0d.mp", i),    64'(bus.mp_count),        64'(tbl[i].e_mp));
      @(posedge clk);
      #1;
    end

    // Randomized run against the behavioural model
    do_reset();
    m_pc = 32'h0; m_bpc = 32'h0; m_btgt = 32'h0;
    m_first = 1'b1; m_prev_mp = 1'b0; m_risk = 1'b0;
    m_br = 0; m_mp = 0; m_sbr = 0; m_smp = 0;
    for (int c = 0; c < 3000; c++) begin
      st  = ($urandom_range(0, 3) == 0);
      pre = ($urandom_range(0, 3) != 0) ? m_pc + 32'd4 : 32'($urandom);
      ev  = !m_first && ($urandom_range(0, 2) == 0);
      epc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom);
      tk  = 1'($urandom_range(0, 1));
      tgt = 32'($urandom);
      act = tk ? tgt : epc + 32'd4;
      pred = ($urandom_range(0, 1) == 0) ? act : 32'($urandom);
      drive(st, pre, ev, epc, tk, tgt, pred);

      mp = ev && !m_first && (act != pred);
      if (m_first)        fv = 1'b0;
      else if (m_prev_mp) fv = !st;
      else                fv = !st && !mp;

      @(negedge clk);
      chk("r.pc",     64'(bus.pc),              64'(m_pc));
      chk("r.fv",     64'(bus.fetch_valid),     64'(fv));
      chk("r.flush",  64'(bus.flush),           64'(mp));
      chk("r.risk",   64'(bus.risk_Ctrl_delay), 64'(m_risk));
      chk("r.bpc",    64'(bus.branch_pc),       64'(m_bpc));
      chk("r.btgt",   64'(bus.branch_target),   64'(m_btgt));
      chk("r.br",     64'(bus.br_count),        64'(m_br));
      chk("r.mp",     64'(bus.mp_count),        64'(m_mp));
      chk("r.sat_br", 64'(sbus.br_count),       64'(m_sbr));
      chk("r.sat_mp", 64'(sbus.mp_count),       64'(m_smp));

      if (mp)                 m_pc = act;
      else if (st || m_first) m_pc = m_pc;
      else                    m_pc = pre;
      m_risk = mp;
      if (mp) begin
        m_bpc  = epc;
        m_btgt = act;
      end
      if (ev && m_br < 64'hFFFF_FFFF) m_br++;
      if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
      if (ev && m_sbr < 7) m_sbr++;
      if (mp && m_smp < 7) m_smp++;
      m_first   = 1'b0;
      m_prev_mp = mp;
      @(posedge clk);
      #1;
    end

    // Saturation on the 3-bit instance, then reset asserted while in REDIR
    do_reset();
    drive(1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h200);
      @(negedge clk);
      if (k == 6) begin
        chk("sat.mp_at_6", 64'(sbus.mp_count), 64'd6);
        chk("sat.mp32_at_6", 64'(bus.mp_count), 64'd6);
      end
      if (k == 7) begin
        chk("sat.mp_at_7", 64'(sbus.mp_count), 64'd7);
        chk("sat.pc_redirect_under_stall", 64'(bus.pc), 64'h104);
        chk("sat.flush", 64'(bus.flush), 64'h1);
      end
      @(posedge clk);
      #1;
    end
    bus.ex_valid = 1'b0;
    #1;
    chk("sat.mp_held", 64'(sbus.mp_count), 64'd7);
    chk("sat.br_held", 64'(sbus.br_count), 64'd7);
    chk("sat.mp32", 64'(bus.mp_count), 64'd8);
    chk("redir.risk_pending", 64'(bus.risk_Ctrl_delay), 64'h1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midredir");
    @(posedge clk);
    #1;
    chk("midredir.risk_after_edge", 64'(bus.risk_Ctrl_delay), 64'h0);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter stage of the fetch pipeline, directly upstream of the branch predictor. It holds the architectural fetch PC and drives it to instruction memory and the predictor. Each cycle it selects the next PC from three sources: the execute-stage redirect, a stall hold, or the predictor's pre_pc. It detects mispredictions, generates the flush and the one-cycle-delayed mispredict strobe plus update PC for the predictor's BHT, and keeps branch statistics counters.

Parameters:
PC_W, 32, width of all PC/target buses
RESET_PC, 32'h0000_0000, fetch address after reset
CNT_W, 32, width of the saturating performance counters

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard unit hold; PC keeps its value
pre_pc  in  PC_W  predicted next PC from branch predictor
ex_valid  in  1  execute stage holds a resolved branch/jalr
ex_pc  in  PC_W  PC of the resolved instruction
ex_taken  in  1  actual branch outcome
ex_target  in  PC_W  actual taken target
ex_pred_pc  in  PC_W  next PC that was predicted for ex_pc (carried down pipeline)
pc  out  PC_W  current fetch PC (to imem and predictor)
fetch_valid  out  1  pc/instruction pair is valid to latch into IF/ID
flush  out  1  kill IF/ID and ID/EX contents this cycle
risk_Ctrl_delay  out  1  registered mispredict strobe to predictor/BHT
branch_pc  out  PC_W  registered PC of the mispredicted instruction
branch_target  out  PC_W  registered corrected next PC
br_count  out  CNT_W  resolved branches since reset
mp_count  out  CNT_W  mispredictions since reset

Behaviour:
- Reset (asynchronous, rst_n low): pc=RESET_PC, state=BOOT, fetch_valid=0, risk_Ctrl_delay=0, branch_pc=0, branch_target=0, br_count=0, mp_count=0. flush is combinational and reads 0 while ex_valid=0.
- actual_pc = ex_taken ? ex_target : ex_pc+4 (PC_W-bit add, wrap modulo 2^PC_W).
- mispredict = ex_valid & (actual_pc != ex_pred_pc); drives flush combinationally in the same cycle.
- Next-PC priority: mispredict -> actual_pc; else stall -> pc; else state==BOOT -> pc (hold RESET_PC); else pre_pc.
- A mispredict overrides stall: the redirect is never lost while stall is high.
- State machine:
  - BOOT: fetch_valid=0 for exactly one cycle after reset release, then RUN. A mispredict in BOOT is ignored, since ex_valid cannot legally be 1 then.
  - RUN: fetch_valid = ~stall & ~mispredict. A mispredict moves to REDIR.
  - REDIR: one cycle; pc already holds actual_pc. fetch_valid = ~stall. Returns to RUN. A new mispredict in REDIR is taken and stays in REDIR.
- Delayed update: on the edge after a mispredict cycle, risk_Ctrl_delay=1, branch_pc=ex_pc and branch_target=actual_pc. risk_Ctrl_delay is a single-cycle pulse unless the next cycle also mispredicts. branch_pc/branch_target hold their values until the next mispredict.
- Counters:
  - br_count increments on every ex_valid cycle.
  - mp_count increments on every mispredict.
  - Both saturate at all-ones, with no wrap.
  - The increment is independent of stall.
- pc[1:0] is taken as given. The block does no alignment check; misaligned targets propagate unchanged.
- Reset asserted mid-redirect: all state returns to reset values immediately, and the pending risk_Ctrl_delay is discarded.

Test Plan:
- Reset release, stall=0, pre_pc=pc+4 model: pc=0 with fetch_valid=0 for 1 cycle, then pc=0,4,8 with fetch_valid=1.
- stall=1 for 3 cycles at pc=0x10: pc holds 0x10, fetch_valid=0; on stall drop the next pc = pre_pc.
- ex_valid=1, ex_pc=0x20, ex_taken=1, ex_target=0x80, ex_pred_pc=0x24: flush=1 same cycle; next pc=0x80. One cycle later risk_Ctrl_delay=1, branch_pc=0x20, branch_target=0x80. mp_count=1, br_count=1.
- Correct prediction (ex_taken=0, ex_pc=0x40, ex_pred_pc=0x44): flush=0, risk_Ctrl_delay stays 0, br_count+1, mp_count unchanged.
- Mispredict with stall=1 (ex_pc=0x100 not taken, ex_pred_pc=0x200): pc becomes 0x104 despite stall; flush=1.
- Force mp_count to all-ones-1, then apply 2 mispredicts: count reaches all-ones and stays there. Assert rst_n mid-REDIR: all outputs return to reset values asynchronously.
